// File: rtl/breath_led_multi_ip_pkg.sv
// rtl/breath_led_multi_ip_pkg.sv - shared register map, mode encoding and response code
package breath_led_multi_pkg;

    // Byte offsets of the register map; channel registers follow CH_BASE at 4-byte pitch.
    localparam logic [31:0] REG_CTRL    = 32'h00;
    localparam logic [31:0] REG_STATUS  = 32'h04;
    localparam logic [31:0] REG_DIV     = 32'h08;
    localparam logic [31:0] REG_CH_BASE = 32'h10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ON     = 2'd1,
        BREATH = 2'd2,
        BLINK  = 2'd3
    } led_mode_t;

    function automatic logic [31:0] ch_addr(input int ch);
        return REG_CH_BASE + (32'(ch) << 2);
    endfunction

endpackage

// File: rtl/breath_led_multi_ip_if.sv
// rtl/breath_led_multi_ip_if.sv - AXI4-Lite port bundle for breath_led_multi_ip
// Five AXI4-Lite channels (AW, W, B, AR, R); master drives addresses/data/VALIDs,
// slave drives READYs and responses.
interface breath_led_multi_ip_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/breath_led_multi_ip_ch.sv
// rtl/breath_led_multi_ip_ch.sv - one LED channel: triangular duty ramp and output select
// Ports: clk, rst_n (async, active low); tick, per_end (prescaler/period strobes);
// pwm_cnt (shared PWM counter); sync (clear ramp); mode, step (channel config);
// led (registered PWM output); dir (ramp direction, 1 = rising).
module breath_led_ch
    import breath_led_multi_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             per_end,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             sync,
    input  led_mode_t        mode,
    input  logic [PWM_W-1:0] step,
    output logic             led,
    output logic             dir
);

    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    logic [PWM_W-1:0] duty;
    logic [PWM_W:0]   sum;
    logic             led_next;
    logic             ramp_step;

    // One extra bit so duty+step can be clamped instead of wrapping.
    assign sum       = {1'b0, duty} + {1'b0, step};
    // per_end is qualified by tick so a held period-end never double-steps.
    assign ramp_step = tick && per_end && (step != '0);

    always_comb begin
        led_next = 1'b0;
        unique case (mode)
            OFF:    led_next = 1'b0;
            ON:     led_next = 1'b1;
            BREATH: led_next = (pwm_cnt < duty);
            BLINK:  led_next = dir;
            default: led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= '0;
            dir  <= 1'b1;
            led  <= 1'b0;
        end else begin
            led <= led_next;
            if (sync) begin
                duty <= '0;
                dir  <= 1'b1;
            end else if (ramp_step) begin
                if (dir) begin
                    if (sum >= {1'b0, DUTY_MAX}) begin
                        duty <= DUTY_MAX;
                        dir  <= 1'b0;
                    end else begin
                        duty <= sum[PWM_W-1:0];
                    end
                end else begin
                    if (duty <= step) begin
                        duty <= '0;
                        dir  <= 1'b1;
                    end else begin
                        duty <= duty - step;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/breath_led_multi_ip.sv
// rtl/breath_led_multi_ip.sv - multi-channel breathing-LED AXI4-Lite peripheral
// Ports: ACLK (single clock); ARESETN (async, active low); s_axi (AXI4-Lite slave
// bundle: AW/W/B/AR/R channels); led_o (NUM_CH PWM outputs, active high).
module breath_led_multi_ip
    import breath_led_multi_pkg::*;
#(
    parameter int NUM_CH             = 4,
    parameter int PWM_W              = 8,
    parameter int DIV_W              = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    breath_led_multi_ip_if.slave s_axi,
    output logic [NUM_CH-1:0]    led_o
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    // AXI slave state
    logic                          aw_ready_q;
    logic                          b_valid_q;
    logic                          ar_ready_q;
    logic                          r_valid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic                          wr_en;
    logic                          rd_en;
    logic [31:0]                   w_off;
    logic [31:0]                   r_off;

    // Register file, prescaler and shared PWM counter
    logic                          en_q;
    logic [DIV_W-1:0]              div_q;
    logic [DIV_W-1:0]              div_cnt;
    logic [DIV_W-1:0]              div_eff;
    logic [PWM_W-1:0]              pwm_cnt;
    logic                          tick;
    logic                          per_end;
    logic                          sync_pulse;
    led_mode_t                     ch_mode [NUM_CH];
    logic [PWM_W-1:0]              ch_step [NUM_CH];
    logic [NUM_CH-1:0]             ch_clr;
    logic [NUM_CH-1:0]             ch_dir;
    logic                          unused_bits;

    assign w_off = 32'({s_axi.awaddr[AW-1:2], 2'b00});
    assign r_off = 32'({s_axi.araddr[AW-1:2], 2'b00});

    assign s_axi.awready = aw_ready_q;
    assign s_axi.wready  = aw_ready_q;
    assign s_axi.bvalid  = b_valid_q;
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.arready = ar_ready_q;
    assign s_axi.rvalid  = r_valid_q;
    assign s_axi.rdata   = r_data_q;
    assign s_axi.rresp   = RESP_OKAY;

    // READY is registered, so the master must hold VALID through the READY cycle.
    assign wr_en = aw_ready_q && s_axi.awvalid && s_axi.wvalid;
    assign rd_en = ar_ready_q && s_axi.arvalid;

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0],
                           s_axi.araddr[1:0], s_axi.wdata, s_axi.wstrb};

    // Write channel: single outstanding transaction, AW and W accepted together.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            aw_ready_q <= !aw_ready_q && s_axi.awvalid && s_axi.wvalid && !b_valid_q;
            if (wr_en) begin
                b_valid_q <= 1'b1;
            end else if (s_axi.bready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Read channel: data captured at the AR handshake, so a coincident write is not seen.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            ar_ready_q <= !ar_ready_q && s_axi.arvalid && !r_valid_q;
            if (rd_en) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_mux;
            end else if (s_axi.rready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en_q  <= 1'b0;
            div_q <= DIV_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                ch_mode[c] <= OFF;
                ch_step[c] <= '0;
            end
        end else if (wr_en) begin
            if (w_off == REG_CTRL && s_axi.wstrb[0]) begin
                en_q <= s_axi.wdata[0];
            end
            if (w_off == REG_DIV) begin
                for (int i = 0; i < DIV_W; i++) begin
                    if (s_axi.wstrb[i/8]) begin
                        div_q[i] <= s_axi.wdata[i];
                    end
                end
            end
            // Addresses beyond the last channel match nothing and are dropped.
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_off == ch_addr(c)) begin
                    if (s_axi.wstrb[0]) begin
                        ch_mode[c] <= led_mode_t'(s_axi.wdata[1:0]);
                    end
                    if (s_axi.wstrb[1]) begin
                        ch_step[c] <= s_axi.wdata[8 +: PWM_W];
                    end
                end
            end
        end
    end

    // SYNC is never stored: it acts on the write cycle itself, so CTRL bit1 reads 0.
    assign sync_pulse = wr_en && (w_off == REG_CTRL) && s_axi.wstrb[0] && s_axi.wdata[1];

    // Writing mode OFF restarts that channel's ramp from the bottom.
    always_comb begin
        ch_clr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_clr[c] = wr_en && (w_off == ch_addr(c)) && s_axi.wstrb[0] &&
                        (s_axi.wdata[1:0] == 2'b00);
        end
    end

    always_comb begin
        rd_mux = '0;
        if (r_off == REG_CTRL) begin
            rd_mux[0] = en_q;
        end else if (r_off == REG_STATUS) begin
            rd_mux[NUM_CH-1:0] = ch_dir;
        end else if (r_off == REG_DIV) begin
            rd_mux[DIV_W-1:0] = div_q;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_off == ch_addr(c)) begin
                rd_mux[1:0]        = ch_mode[c];
                rd_mux[8 +: PWM_W] = ch_step[c];
            end
        end
    end

    // DIV=0 behaves as DIV=1. The >= keeps the wrap safe if DIV shrinks below div_cnt.
    assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    assign tick    = en_q && (div_cnt >= div_eff - DIV_W'(1));
    assign per_end = tick && (pwm_cnt == '1);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (en_q) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            end
            if (sync_pulse) begin
                pwm_cnt <= '0;
            end else if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        breath_led_ch #(
            .PWM_W (PWM_W)
        ) u_ch (
            .clk     (ACLK),
            .rst_n   (ARESETN),
            .tick    (tick),
            .per_end (per_end),
            .pwm_cnt (pwm_cnt),
            .sync    (sync_pulse | ch_clr[g]),
            .mode    (ch_mode[g]),
            .step    (ch_step[g]),
            .led     (led_o[g]),
            .dir     (ch_dir[g])
        );
    end

endmodule

// File: tb/tb_breath_led_multi_ip.sv
// tb/tb_breath_led_multi_ip.sv - self-checking bench for breath_led_multi_ip
module tb_breath_led_multi_ip;
    import breath_led_multi_pkg::*;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] led_o;

    always #5 clk = ~clk;

    breath_led_multi_ip_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    breath_led_multi_ip #(
        .NUM_CH(NUM_CH), .PWM_W(8), .DIV_W(16),
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .s_axi   (bus),
        .led_o   (led_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int                m_en, m_div, m_div_cnt, m_pwm, m_pe_cnt;
    int                m_mode [NUM_CH];
    int                m_step [NUM_CH];
    int                m_duty [NUM_CH];
    int                m_dir  [NUM_CH];
    logic [NUM_CH-1:0] m_led;
    int                hist2[$];

    always @(posedge clk or negedge rst_n) begin : model
        bit          wr, sync, tick, pe, clr;
        int          waddr, eff;
        logic [31:0] wdat;
        logic [3:0]  ws;
        if (!rst_n) begin
            m_en = 0; m_div = 1; m_div_cnt = 0; m_pwm = 0; m_led = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 0; m_step[c] = 0; m_duty[c] = 0; m_dir[c] = 1;
            end
        end else begin
            wr    = bus.awvalid && bus.awready && bus.wvalid && bus.wready;
            waddr = int'(bus.awaddr) & 'h3C;
            wdat  = bus.wdata;
            ws    = bus.wstrb;
            sync  = wr && waddr == 0 && ws[0] && wdat[1];
            eff   = (m_div == 0) ? 1 : m_div;
            tick  = (m_en != 0) && (m_div_cnt >= eff - 1);
            pe    = tick && m_pwm == 255;
            for (int c = 0; c < NUM_CH; c++) begin
                case (m_mode[c])
                    1:       m_led[c] = 1'b1;
                    2:       m_led[c] = (m_pwm < m_duty[c]);
                    3:       m_led[c] = (m_dir[c] != 0);
                    default: m_led[c] = 1'b0;
                endcase
                clr = sync || (wr && waddr == 16 + 4*c && ws[0] && wdat[1:0] == 2'b00);
                if (clr) begin
                    m_duty[c] = 0; m_dir[c] = 1;
                end else if (pe && m_step[c] != 0) begin
                    if (m_dir[c] != 0) begin
                        m_duty[c] = (m_duty[c] + m_step[c] > 255) ? 255 : m_duty[c] + m_step[c];
                        if (m_duty[c] == 255) m_dir[c] = 0;
                    end else begin
                        m_duty[c] = (m_duty[c] - m_step[c] < 0) ? 0 : m_duty[c] - m_step[c];
                        if (m_duty[c] == 0) m_dir[c] = 1;
                    end
                end
            end
            if (pe) begin
                m_pe_cnt++;
                hist2.push_back(m_duty[2]);
            end
            m_pwm = sync ? 0 : (tick ? (m_pwm + 1) % 256 : m_pwm);
            if (m_en != 0) m_div_cnt = tick ? 0 : m_div_cnt + 1;
            if (wr) begin
                if (waddr == 0 && ws[0]) m_en = int'(wdat[0]);
                if (waddr == 8) begin
                    if (ws[0]) m_div = (m_div & 'hFF00) | int'(wdat[7:0]);
                    if (ws[1]) m_div = (m_div & 'h00FF) | (int'(wdat[15:8]) << 8);
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (waddr == 16 + 4*c) begin
                        if (ws[0]) m_mode[c] = int'(wdat[1:0]);
                        if (ws[1]) m_step[c] = int'(wdat[15:8]);
                    end
                end
            end
        end
    end

    function automatic logic [NUM_CH-1:0] m_status();
        logic [NUM_CH-1:0] s;
        for (int c = 0; c < NUM_CH; c++) s[c] = (m_dir[c] != 0);
        return s;
    endfunction

    bit cmp_on = 0;
    always @(negedge clk) begin
        if (cmp_on) check("led_o", 32'(led_o), 32'(m_led));
    end

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int skew, input bit hold_b);
        int budget;
        int n;
        @(negedge clk);
        if (skew >= 0) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
        if (skew <= 0) begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
        n = (skew < 0) ? -skew : skew;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("no_ready_on_half", 32'({bus.awready, bus.wready}), 32'h0);
        end
        if (skew > 0) begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
        if (skew < 0) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
        budget = 0;
        while (!bus.awready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("aw_w_ready", 32'({bus.awready, bus.wready}), 32'h3);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("ready_pulse", 32'({bus.awready, bus.wready}), 32'h0);
        check("bvalid_rise", 32'(bus.bvalid), 32'h1);
        check("bresp", 32'(bus.bresp), 32'h0);
        if (!hold_b) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("bvalid_hold", 32'(bus.bvalid), 32'h1);
            end
            bus.bready = 1'b1;
            @(negedge clk);
            bus.bready = 1'b0;
            check("bvalid_fall", 32'(bus.bvalid), 32'h0);
        end
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                            output logic [NUM_CH-1:0] st_exp);
        int budget;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        budget = 0;
        while (!bus.arready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        st_exp = m_status();
        check("ar_ready", 32'(bus.arready), 32'h1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("ar_pulse", 32'(bus.arready), 32'h0);
        check("rvalid_rise", 32'(bus.rvalid), 32'h1);
        check("rresp", 32'(bus.rresp), 32'h0);
        data = bus.rdata;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("rdata_hold", bus.rdata, data);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("rvalid_fall", 32'(bus.rvalid), 32'h0);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        axi_write(addr, data, 4'hF, 0, 1'b0);
    endtask

    task automatic rd_check(input string name, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0]       d;
        logic [NUM_CH-1:0] s;
        axi_read(addr, d, s);
        check(name, d, exp);
    endtask

    task automatic status_check(input string name);
        logic [31:0]       d;
        logic [NUM_CH-1:0] s;
        axi_read(6'h04, d, s);
        check(name, d, 32'(s));
    endtask

    task automatic wait_per_end(input int n);
        int target;
        int budget;
        target = m_pe_cnt + n;
        budget = 0;
        while (m_pe_cnt < target && budget < n * 1100 + 100) begin
            @(negedge clk);
            budget++;
        end
        check("per_end_reached", 32'(m_pe_cnt >= target), 32'h1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0]       d;
        logic [NUM_CH-1:0] s;
        int                exp_seq [4];
        int                blink_exp [4];
        int                ch;
        exp_seq   = '{128, 255, 127, 0};
        blink_exp = '{1, 0, 0, 1};

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_on = 1;

        // Reset state
        check("reset_led", 32'(led_o), 32'h0);
        check("reset_bvalid", 32'(bus.bvalid), 32'h0);
        rd_check("reset_ctrl", 6'h00, 32'h0);
        rd_check("reset_div", 6'h08, 32'h1);
        rd_check("reset_ch0", 6'h10, 32'h0);
        rd_check("reset_status", 6'h04, 32'hF);

        // Static ON
        wr(6'h10, 32'h1);
        wr(6'h14, 32'h1);
        rd_check("ch0_on_rb", 6'h10, 32'h1);
        rd_check("ch1_on_rb", 6'h14, 32'h1);
        repeat (2) @(negedge clk);
        check("on_led_lo", 32'(led_o[1:0]), 32'h3);
        check("on_led_hi", 32'(led_o[3:2]), 32'h0);

        // Breath on CH0; random config on CH1 and CH3
        wr(6'h08, 32'h1);
        wr(6'h10, 32'h0402);
        wr(6'h14, 32'($urandom_range(0, 255)) << 8 | 32'($urandom_range(1, 3)));
        wr(6'h1C, 32'($urandom_range(0, 255)) << 8 | 32'($urandom_range(0, 3)));
        wr(6'h00, 32'h1);
        wait_per_end(64);
        check("breath_top_model", 32'(m_duty[0]), 32'd255);
        axi_read(6'h04, d, s);
        check("breath_top_status0", 32'(d[0]), 32'h0);
        check("breath_top_status", d, 32'(s));
        wait_per_end(64);
        check("breath_bottom_model", 32'(m_duty[0]), 32'd0);
        axi_read(6'h04, d, s);
        check("breath_bottom_status0", 32'(d[0]), 32'h1);

        // Blink on CH2 with STEP=0x80
        wr(6'h18, 32'h8003);
        hist2.delete();
        for (int i = 0; i < 4; i++) begin
            wait_per_end(1);
            repeat (128) @(negedge clk);
            check($sformatf("blink_led_%0d", i), 32'(led_o[2]), 32'(blink_exp[i]));
        end
        check("blink_hist_len", 32'(hist2.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("blink_duty_%0d", i), (i < hist2.size()) ? 32'(hist2[i]) : 32'hFFFF,
                  32'(exp_seq[i]));
        end

        // SYNC mid-ramp
        repeat (77) @(negedge clk);
        wr(6'h00, 32'h3);
        for (int c = 0; c < NUM_CH; c++) check("sync_duty_model", 32'(m_duty[c]), 32'd0);
        rd_check("sync_status", 6'h04, 32'hF);
        rd_check("sync_ctrl", 6'h00, 32'h1);

        // Byte-lane write touches STEP only
        wr(6'h10, 32'h0402);
        axi_write(6'h10, 32'h00000A03, 4'b0010, 0, 1'b0);
        rd_check("wstrb_step_only", 6'h10, 32'h0A02);

        // Unmapped / out-of-range addresses
        wr(6'h3C, 32'hFFFFFFFF);
        rd_check("oor_3c", 6'h3C, 32'h0);
        rd_check("unmapped_0c", 6'h0C, 32'h0);
        rd_check("oor_no_side_effect", 6'h1C, 32'(m_step[3] << 8 | m_mode[3]));

        // AW/W skew
        axi_write(6'h1C, 32'h2002, 4'hF, 3, 1'b0);
        rd_check("skew_aw_first", 6'h1C, 32'h2002);
        axi_write(6'h18, 32'h1001, 4'hF, -3, 1'b0);
        rd_check("skew_w_first", 6'h18, 32'h1001);

        // Randomized traffic
        for (int it = 0; it < 12; it++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            if (it == 5) begin
                axi_write(6'h08, 32'($urandom_range(0, 3)), 4'hF, 0, 1'b0);
            end else begin
                axi_write(6'(16 + 4*ch), $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 4)) - 2, 1'b0);
            end
            repeat ($urandom_range(100, 1500)) @(negedge clk);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            rd_check($sformatf("rand_ch%0d_rb", c), 6'(16 + 4*c),
                     32'(m_step[c] << 8 | m_mode[c]));
        end
        status_check("rand_status");

        // Reset asserted while BVALID is pending
        wr(6'h10, 32'h1);
        repeat (3) @(negedge clk);
        check("pre_reset_led0", 32'(led_o[0]), 32'h1);
        axi_write(6'h14, 32'h1, 4'hF, 0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bvalid_clr", 32'(bus.bvalid), 32'h0);
        check("async_led_clr", 32'(led_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_replay_bvalid", 32'(bus.bvalid), 32'h0);
        end
        rd_check("post_reset_ctrl", 6'h00, 32'h0);
        rd_check("post_reset_div", 6'h08, 32'h1);
        rd_check("post_reset_ch0", 6'h10, 32'h0);

        cmp_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/breath_led_multi_ip.md
Name: breath_led_multi_ip

Overview:
Multi-channel successor to the single-channel breathing-LED AXI4-Lite peripheral. It drives NUM_CH independent PWM LED outputs, and each channel is set by register to off, on, breath or blink. Breath is a triangular duty ramp and blink is a square wave derived from the same ramp. The block sits behind the PS AXI interconnect as an AXI4-Lite slave and drives the LED pins directly.

Parameters:
NUM_CH, 4, number of LED channels (1..8)
PWM_W, 8, PWM counter/duty width in bits
DIV_W, 16, prescaler width
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
C_S_AXI_ADDR_WIDTH, 6, AXI byte-address width

Ports:
ACLK  in  1  single clock for AXI and PWM logic
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_W/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
led_o  out  NUM_CH  PWM LED outputs, active high

Behaviour:
- Reset: all READY/VALID outputs, RDATA, led_o, counters and registers are 0. DIV resets to 0x0001 and every channel mode to OFF.
- Register map (word aligned):
  - 0x00 CTRL: bit0 EN; bit1 SYNC, write-1 pulse that self-clears next cycle and reads 0.
  - 0x04 STATUS, RO: bit[ch] is the ramp direction, 1 = rising.
  - 0x08 DIV: [DIV_W-1:0].
  - 0x10+4*ch CHn: [1:0] MODE (0 off, 1 on, 2 breath, 3 blink); [15:8] STEP, low PWM_W bits used.
- Unmapped or out-of-range channel address: read returns 0, write is ignored. RESP is always OKAY (2'b00).
- AXI write:
  - One transaction outstanding.
  - AWREADY and WREADY assert together for exactly one cycle once AWVALID and WVALID are both high and BVALID is low.
  - The register updates on that cycle, per WSTRB byte lane.
  - BVALID rises the next cycle and holds until BREADY.
- AXI read:
  - ARREADY pulses one cycle when ARVALID is high and RVALID is low.
  - RVALID and RDATA appear the next cycle and hold stable until RREADY.
  - Read and write are independent. A same-cycle read of a register being written returns the old value.
- Prescaler:
  - div_cnt counts 0..DIV-1 while EN=1.
  - tick is one cycle high when div_cnt wraps. DIV=0 is treated as 1 (tick every cycle).
  - EN=0 holds div_cnt, pwm_cnt and ramps frozen; led_o follows the frozen compare.
- PWM:
  - Shared pwm_cnt (PWM_W bits) increments on tick and wraps at 2^PWM_W-1 -> 0.
  - per_end = tick AND pwm_cnt = all-ones.
- Per-channel ramp, updated on per_end:
  - If dir=1: duty = min(duty+STEP, MAX), with MAX = 2^PWM_W-1. Reaching MAX sets dir=0.
  - If dir=0: duty = max(duty-STEP, 0). Reaching 0 sets dir=1.
  - Compute in PWM_W+1 bits so there is no wrap-around.
  - STEP=0 freezes the ramp.
  - Reset state is duty=0, dir=1.
- Outputs (registered, one cycle after compare):
  - OFF: led_o=0.
  - ON: led_o=1.
  - BREATH: led_o = (pwm_cnt < duty).
  - BLINK: led_o = dir.
- Mode write: the ramp keeps its state across mode changes. Writing OFF clears that channel's duty to 0 and dir to 1.
- SYNC: all channels' duty→0, dir→1 and pwm_cnt→0 in the same cycle. SYNC has priority over a coincident per_end.
- ARESETN assertion mid-transaction drops all VALID/READY immediately. No transaction is replayed after release.

Decomposition:
- Package breath_led_multi_pkg holds:
  - register offset localparams (CTRL, STATUS, DIV, CH_BASE);
  - mode enum led_mode_t {OFF, ON, BREATH, BLINK};
  - the RESP_OKAY constant.
- One sub-module, breath_led_ch, is instantiated NUM_CH times via generate. Its inputs are tick/per_end/pwm_cnt/sync/mode/step; its outputs are led and dir.
- The top holds the AXI slave, the register file, the prescaler and pwm_cnt.

Test Plan:
- Reset then read 0x00, 0x08 and 0x10 -> 0x0, 0x1 and 0x0; led_o=0; all write and read responses are OKAY.
- Write 0x10=0x1 and 0x14=0x1, then read back -> 0x1. led_o[1:0]=2'b11 within 2 cycles and led_o[3:2]=0.
- DIV=1, CH0=0x0402 (breath, STEP=4), EN=1:
  - duty reaches 0xFF after 64 periods (256 ticks each);
  - STATUS bit0 then reads 0; duty returns to 0 after 64 more periods;
  - the high time per period equals duty.
- CH2 blink with STEP=0x80:
  - duty sequence 0x80, 0xFF, 0x7F, 0x00;
  - led_o[2] follows dir, so it is 1 for 2 periods then 0 for 2 periods.
- Write 0x00=0x3 mid-ramp -> CTRL reads back 0x1; all duties are 0 and STATUS = all-ones next cycle.
- Edge cases:
  - WSTRB=4'b0010 write to CH0 changes STEP only;
  - a write to 0x3C with NUM_CH=4 is ignored and reads 0;
  - an AW/W skew of 3 cycles still completes exactly one write;
  - ARESETN pulled low during BVALID clears BVALID and led_o asynchronously.
